// File: rtl/halfword_serializer.sv
// halfword_serializer: narrows 32-bit words into 16-bit beats, lower half first, over valid/ready.
// Define HALFWORD_SERIALIZER_ZERO_SKIP_EN to emit a single beat for words whose upper half is zero.
module halfword_serializer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      out_half,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_upper,
  output logic             out_last,
  output logic [CNT_W-1:0] word_count
);

`ifdef HALFWORD_SERIALIZER_ZERO_SKIP_EN
  localparam logic SKIP_EN = 1'b1;
`else
  localparam logic SKIP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      word_q, word_d;
  logic [15:0]      half_q, half_d;
  logic             valid_q, valid_d;
  logic             upper_q, upper_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             final_hs_s;
  logic             accept_s;
  logic             load_s;
  logic             to_hi_s;
  logic             to_idle_s;

  // A low beat is also the final beat only when skipping is built in and the upper half is zero.
  function automatic logic lo_is_last(input logic [31:0] w);
    return SKIP_EN & (w[31:16] == 16'h0000);
  endfunction

  assign final_hs_s = valid_q & out_ready & last_q;
  // Masked by rst so every output reads 0 while reset is held.
  assign in_ready   = ~rst & ((state_q == IDLE) | final_hs_s);
  assign accept_s   = in_valid & in_ready;

  // Decide which transition the FSM takes this cycle.
  always_comb begin
    load_s    = 1'b0;
    to_hi_s   = 1'b0;
    to_idle_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      SEND_LO: begin
        if (out_ready && last_q) begin
          load_s    = accept_s;
          to_idle_s = ~accept_s;
        end else if (out_ready) begin
          to_hi_s = 1'b1;
        end else begin
          to_hi_s = 1'b0;
        end
      end
      SEND_HI: begin
        if (out_ready) begin
          load_s    = accept_s;
          to_idle_s = ~accept_s;
        end else begin
          to_idle_s = 1'b0;
        end
      end
      default: begin
        to_idle_s = 1'b1;
      end
    endcase
  end

  // Next-state values for the state, held word, registered beat outputs and counter.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    half_d  = half_q;
    valid_d = valid_q;
    upper_d = upper_q;
    last_d  = last_q;
    if (final_hs_s) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
    if (load_s) begin
      state_d = SEND_LO;
      word_d  = in_word;
      half_d  = in_word[15:0];
      valid_d = 1'b1;
      upper_d = 1'b0;
      last_d  = lo_is_last(in_word);
    end else if (to_hi_s) begin
      state_d = SEND_HI;
      half_d  = word_q[31:16];
      valid_d = 1'b1;
      upper_d = 1'b1;
      last_d  = 1'b1;
    end else if (to_idle_s) begin
      state_d = IDLE;
      half_d  = 16'h0000;
      valid_d = 1'b0;
      upper_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers; reset discards any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= 32'h0000_0000;
      half_q  <= 16'h0000;
      valid_q <= 1'b0;
      upper_q <= 1'b0;
      last_q  <= 1'b0;
      count_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      half_q  <= half_d;
      valid_q <= valid_d;
      upper_q <= upper_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  assign out_half   = half_q;
  assign out_valid  = valid_q;
  assign out_upper  = upper_q;
  assign out_last   = last_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_halfword_serializer.sv
// Bench for halfword_serializer: a queue-of-beats model checked every cycle, directed scenarios
// with literal expectations, then a randomized phase.
module tb_halfword_serializer;

`ifdef HALFWORD_SERIALIZER_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_word = 32'h0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_upper, out_last;
  logic [15:0] out_half;
  logic [15:0] word_count;
  logic        in_ready2, out_valid2, out_upper2, out_last2;
  logic [15:0] out_half2;
  logic [1:0]  word_count2;

  halfword_serializer #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
    .out_half(out_half), .out_valid(out_valid), .out_ready(out_ready),
    .out_upper(out_upper), .out_last(out_last), .word_count(word_count));

  halfword_serializer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready2),
    .out_half(out_half2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_upper(out_upper2), .out_last(out_last2), .word_count(word_count2));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] half;
    logic        upper;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       seen_q[$];
  int          seen_cyc[$];
  int          cyc = 0;
  int unsigned model_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a word becomes one or two beats in a queue; a beat leaves on a handshake.
  always @(negedge clk) begin
    bit    exp_valid, exp_ready;
    beat_t b;
    cyc++;
    if (rst) begin
      exp_q.delete();
      model_cnt = 0;
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_out_half", {16'h0, out_half}, 32'h0);
      chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
      chk("rst_count", {16'h0, word_count}, 32'h0);
    end else begin
      exp_valid = (exp_q.size() > 0);
      exp_ready = !exp_valid || (out_ready && exp_q[0].last);
      chk("out_valid", {31'h0, out_valid}, {31'h0, exp_valid});
      if (exp_valid) b = exp_q[0];
      else           b = '0;
      chk("out_half", {16'h0, out_half}, {16'h0, b.half});
      chk("out_upper", {31'h0, out_upper}, {31'h0, b.upper});
      chk("out_last", {31'h0, out_last}, {31'h0, b.last});
      chk("in_ready", {31'h0, in_ready}, {31'h0, exp_ready});
      chk("word_count", {16'h0, word_count}, model_cnt & 32'hFFFF);
      chk("word_count_w2", {30'h0, word_count2}, model_cnt & 32'h3);
      if (exp_valid && out_ready) begin
        seen_q.push_back(b);
        seen_cyc.push_back(cyc);
        if (b.last) model_cnt++;
        void'(exp_q.pop_front());
      end
      if (in_valid && exp_ready) begin
        if (SKIP && in_word[31:16] == 16'h0) begin
          exp_q.push_back('{half: in_word[15:0], upper: 1'b0, last: 1'b1});
        end else begin
          exp_q.push_back('{half: in_word[15:0], upper: 1'b0, last: 1'b0});
          exp_q.push_back('{half: in_word[31:16], upper: 1'b1, last: 1'b1});
        end
      end
    end
  end

  task automatic put_word(input logic [31:0] w);
    bit ok = 1'b0;
    in_word  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 32'h0, 32'h1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0);
    end
    if (!done) chk("drain_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string nm, input int idx, input logic [15:0] h,
                          input logic u, input logic l);
    if (idx < seen_q.size()) begin
      chk(nm, {14'h0, seen_q[idx].half, seen_q[idx].upper, seen_q[idx].last},
              {14'h0, h, u, l});
    end else begin
      chk({nm, "_missing"}, 32'h0, 32'h1);
    end
  endtask

  logic [1:0]  wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [31:0] b2b_words [3] = '{32'h0001_0002, 32'h0003_0004, 32'h0005_0006};
  logic [15:0] b2b_beats [6] = '{16'h0002, 16'h0001, 16'h0004, 16'h0003, 16'h0006, 16'h0005};

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("post_rst_out_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk);
    #1;

    // Basic word.
    out_ready = 1'b1;
    base = seen_q.size();
    put_word(32'h1234_ABCD);
    drain();
    chk_beat("basic_lo", base, 16'hABCD, 1'b0, 1'b0);
    chk_beat("basic_hi", base + 1, 16'h1234, 1'b1, 1'b1);
    chk("basic_count", {16'h0, word_count}, 32'd1);

    // Back-to-back words with no bubbles.
    base = seen_q.size();
    for (int i = 0; i < 3; i++) put_word(b2b_words[i]);
    drain();
    for (int i = 0; i < 6; i++) chk_beat("b2b_beat", base + i, b2b_beats[i], i[0], i[0]);
    for (int i = 0; i < 5; i++)
      if (base + i + 1 < seen_cyc.size())
        chk("b2b_gap", seen_cyc[base + i + 1] - seen_cyc[base + i], 32'd1);
    chk("b2b_count", {16'h0, word_count}, 32'd4);

    // Backpressure: out_ready 1,0,0,1.
    base = seen_q.size();
    put_word(32'hCAFE_F00D);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(posedge clk); #1 out_ready = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    drain();
    chk_beat("bp_lo", base, 16'hF00D, 1'b0, 1'b0);
    chk_beat("bp_hi", base + 1, 16'hCAFE, 1'b1, 1'b1);
    chk("bp_count", {16'h0, word_count}, 32'd5);

    // Zero-upper word.
    base = seen_q.size();
    put_word(32'h0000_BEEF);
    drain();
    chk_beat("zs_lo", base, 16'hBEEF, 1'b0, SKIP);
    if (!SKIP) chk_beat("zs_hi", base + 1, 16'h0000, 1'b1, 1'b1);
    chk("zs_beats", seen_q.size() - base, SKIP ? 32'd1 : 32'd2);
    chk("zs_count", {16'h0, word_count}, 32'd6);

    // Asynchronous reset in the middle of SEND_HI.
    put_word(32'hDEAD_BEEF);
    @(posedge clk); #1 out_ready = 1'b0;
    chk("pre_rst_upper", {31'h0, out_upper}, 32'h1);
    chk("pre_rst_half", {16'h0, out_half}, 32'h0000_DEAD);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", {31'h0, out_valid}, 32'h0);
    chk("async_half", {16'h0, out_half}, 32'h0);
    chk("async_upper_last", {30'h0, out_upper, out_last}, 32'h0);
    chk("async_count", {16'h0, word_count}, 32'h0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rel_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rel_count", {16'h0, word_count}, 32'h0);
    @(posedge clk); #1;

    // Counter wrap on the 2-bit instance.
    for (int i = 0; i < 5; i++) begin
      put_word(32'h1111_0000 + i);
      drain();
      chk("wrap_count", {30'h0, word_count2}, {30'h0, wrap_exp[i]});
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_word   = ($urandom_range(0, 3) == 0) ? {16'h0, 16'($urandom)} : $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
